// File: rtl/fp_norm_ctrl.sv
// Normalization sequencer for the FPU add/sub path: leading-zero count,
// exponent-clamped left shift through the shared Lshift24, valid/ready result.
module Lshift24 (
    input  logic [23:0] A,
    input  logic [4:0]  shl,
    output logic [23:0] OUT
);
    assign OUT = A << shl;
endmodule

module fp_norm_ctrl #(
    parameter int unsigned MW = 24,
    parameter int unsigned EW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [MW-1:0] in_mant,
    input  logic [EW-1:0] in_exp,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW-1:0] out_mant,
    output logic [EW-1:0] out_exp,
    output logic          out_zero,
    output logic          out_unf,
    output logic          busy
);
    localparam int unsigned LZW = 5;

    typedef enum logic [1:0] {IDLE, CALC, SHIFT, DONE} state_t;

    state_t         state, state_nxt;
    logic [MW-1:0]  m_r;
    logic [EW-1:0]  e_r;
    logic [LZW-1:0] shl_r;
    logic [EW-1:0]  exp_r;
    logic           zero_r, unf_r;

    logic [LZW-1:0] lz;
    logic [LZW-1:0] shl_d;
    logic [EW-1:0]  exp_d;
    logic           zero_d, unf_d;
    logic [MW-1:0]  sh_out;
    logic           in_ready_d, out_valid_d, busy_d;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = CALC;
            CALC:    state_nxt = SHIFT;
            SHIFT:   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake/status outputs, registered from the next state
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b1;
        if (state_nxt == IDLE) begin
            in_ready_d = 1'b1;
            busy_d     = 1'b0;
        end
        if (state_nxt == DONE) out_valid_d = 1'b1;
    end

    // Leading-zero count; the highest set bit wins, 24 when m_r is zero
    always_comb begin
        lz = LZW'(MW);
        for (int i = 0; i < MW; i++) begin
            if (m_r[i]) lz = LZW'(MW - 1 - i);
        end
    end

    // Shift amount and exponent; clamps so the exponent never drops below the denormal encoding
    always_comb begin
        shl_d  = '0;
        exp_d  = '0;
        zero_d = 1'b0;
        unf_d  = 1'b0;
        if (m_r == '0) begin
            zero_d = 1'b1;
        end else if (e_r > EW'(lz)) begin
            shl_d = lz;
            exp_d = e_r - EW'(lz);
        end else if (e_r != '0) begin
            shl_d = LZW'(e_r - EW'(1));
            unf_d = 1'b1;
        end else begin
            unf_d = 1'b1;
        end
    end

    Lshift24 u_lshift (
        .A   (m_r),
        .shl (shl_r),
        .OUT (sh_out)
    );

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_r       <= '0;
            e_r       <= '0;
            shl_r     <= '0;
            exp_r     <= '0;
            zero_r    <= 1'b0;
            unf_r     <= 1'b0;
            out_mant  <= '0;
            out_exp   <= '0;
            out_zero  <= 1'b0;
            out_unf   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
            case (state)
                IDLE: if (in_valid) begin
                    m_r <= in_mant;
                    e_r <= in_exp;
                end
                CALC: begin
                    shl_r  <= shl_d;
                    exp_r  <= exp_d;
                    zero_r <= zero_d;
                    unf_r  <= unf_d;
                end
                SHIFT: begin
                    out_mant <= sh_out;
                    out_exp  <= exp_r;
                    out_zero <= zero_r;
                    out_unf  <= unf_r;
                end
                default: ;
            endcase
        end
    end
endmodule
